immgen_stage: RTL and testbench

IMMGEN_STAGE -- requirements
Module: immgen_stage

---
 rtl/immgen_stage.sv | 121 ++++++++++++
 tb/tb_immgen_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/immgen_stage.sv
// immgen_stage: RISC-V immediate generator with PC-relative target, one-cycle
// registered output and a two-entry (main + skid) elastic buffer.
// Optional macro IMMGEN_ZIMM_EN enables the CSR zimm (Z) format on sel=5;
// without it sel=5 is reported as illegal and no zimm logic is built.
`timescale 1ns/1ps

module immgen_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [24:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam int unsigned IW = 25;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } entry_t;

    // Instruction bits renumbered to their architectural positions [31:7]
    logic [31:7] ins_c;
    assign ins_c = in_inst[IW-1:0];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [XLEN-1:0] imm_c;
    logic            illegal_c;
    entry_t          new_c;

    // Immediate formation per format select
    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        case (in_sel)
            3'd0: imm_c = sext32({{20{ins_c[31]}}, ins_c[31:20]});
            3'd1: imm_c = sext32({{20{ins_c[31]}}, ins_c[31:25], ins_c[11:7]});
            3'd2: imm_c = sext32({{19{ins_c[31]}}, ins_c[31], ins_c[7],
                                  ins_c[30:25], ins_c[11:8], 1'b0});
            3'd3: imm_c = sext32({ins_c[31:12], 12'b0});
            3'd4: imm_c = sext32({{11{ins_c[31]}}, ins_c[31], ins_c[19:12],
                                  ins_c[20], ins_c[30:21], 1'b0});
`ifdef IMMGEN_ZIMM_EN
            3'd5: imm_c = XLEN'(ins_c[19:15]);
`endif
            default: illegal_c = 1'b1;
        endcase
        new_c.illegal = illegal_c;
        new_c.imm     = imm_c;
        new_c.target  = in_pc + imm_c;
    end

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   accept_c, drain_c;

    assign accept_c = in_valid && in_ready;
    assign drain_c  = main_valid_q && out_ready;

    // Main/skid steering: skid refills main on drain, new beats fill the first free slot
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || drain_c) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept_c;
                if (accept_c) begin
                    skid_d = new_c;
                end
            end else begin
                main_valid_d = accept_c;
                if (accept_c) begin
                    main_d = new_c;
                end
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_d       = new_c;
        end
    end

    // State registers with synchronous reset clearing both entries
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Ready depends only on the skid flop (and reset), never on out_ready
    assign in_ready    = !skid_valid_q && !rst;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_target  = main_q.target;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a queue model plus directed literal vectors.
`timescale 1ns/1ps

module tb_immgen_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready;
    logic [2:0]  in_sel;
    logic [24:0] in_inst;
    logic [63:0] pc64;
    logic [31:0] pc32;
    assign pc32 = pc64[31:0];

    logic        r32, v32, ill32, r64, v64, ill64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic exp_rdy;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    exp_t q[$];

    immgen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32),
        .in_sel(in_sel), .in_inst(in_inst), .in_pc(pc32),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_target(tgt32), .out_illegal(ill32)
    );

    immgen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
        .in_sel(in_sel), .in_inst(in_inst), .in_pc(pc64),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_target(tgt64), .out_illegal(ill64)
    );

    // Reference immediate from whole-word arithmetic on the instruction
    function automatic exp_t model(input logic [2:0] s, input logic [24:0] i25,
                                   input logic [63:0] pc);
        exp_t   e;
        int     ins;
        longint x;
        longint imm;
        ins   = {i25, 7'b0};
        x     = ins;
        imm   = 0;
        e.ill = 1'b0;
        case (s)
            3'd0: imm = x >>> 20;
            3'd1: imm = ((x >>> 25) <<< 5) | ((x >> 7) & 31);
            3'd2: imm = ((x >>> 31) <<< 12) | (((x >> 7) & 1) << 11)
                      | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
            3'd3: imm = x & longint'(-4096);
            3'd4: imm = ((x >>> 31) <<< 20) | (((x >> 12) & 255) << 12)
                      | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
`ifdef IMMGEN_ZIMM_EN
            3'd5: imm = (x >> 15) & 31;
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = e.ill ? 64'd0 : imm;
        e.tgt = pc + e.imm;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Per-cycle scoreboard on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_rst64", 64'(r64), 64'd0);
            chk("in_ready_rst32", 64'(r32), 64'd0);
            q.delete();
        end else begin
            exp_rdy = (q.size() < 2);
            chk("in_ready64", 64'(r64), 64'(exp_rdy));
            chk("in_ready32", 64'(r32), 64'(exp_rdy));
            chk("out_valid64", 64'(v64), 64'(q.size() != 0));
            chk("out_valid32", 64'(v32), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("imm64", imm64, q[0].imm);
                chk("tgt64", tgt64, q[0].tgt);
                chk("ill64", 64'(ill64), 64'(q[0].ill));
                chk("imm32", 64'(imm32), {32'd0, q[0].imm[31:0]});
                chk("tgt32", 64'(tgt32), {32'd0, q[0].tgt[31:0]});
                chk("ill32", 64'(ill32), 64'(q[0].ill));
                if (out_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
            end
            if (in_valid && exp_rdy) q.push_back(model(in_sel, in_inst, pc64));
        end
    end

    // Hold a beat until accepted; entered and left at posedge+1
    task automatic send(input logic [2:0] s, input logic [31:0] inst, input logic [63:0] pc);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_inst  = inst[31:7];
        pc64     = pc;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = r64;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    // Single beat with literal expectations, also pinning the model
    task automatic dir(input string nm, input logic [2:0] s, input logic [31:0] inst,
                       input logic [63:0] pc, input logic [63:0] ei, input logic [63:0] et,
                       input logic eill, input bit use32);
        exp_t m;
        m = model(s, inst[31:7], pc);
        out_ready = 1'b1;
        send(s, inst, pc);
        @(negedge clk);
        if (use32) begin
            chk({nm, "_valid"}, 64'(v32), 64'd1);
            chk({nm, "_imm"}, 64'(imm32), {32'd0, ei[31:0]});
            chk({nm, "_tgt"}, 64'(tgt32), {32'd0, et[31:0]});
            chk({nm, "_ill"}, 64'(ill32), 64'(eill));
            chk({nm, "_model_imm"}, {32'd0, m.imm[31:0]}, {32'd0, ei[31:0]});
        end else begin
            chk({nm, "_valid"}, 64'(v64), 64'd1);
            chk({nm, "_imm"}, imm64, ei);
            chk({nm, "_tgt"}, tgt64, et);
            chk({nm, "_ill"}, 64'(ill64), 64'(eill));
            chk({nm, "_model_imm"}, m.imm, ei);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sel = 3'd0; in_inst = '0; pc64 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(v64), 64'd0);
        chk("rst_out_imm", imm64, 64'd0);
        chk("rst_out_target", tgt64, 64'd0);
        chk("rst_out_illegal", 64'(ill64), 64'd0);
        chk("rst_in_ready", 64'(r64), 64'd1);
        @(posedge clk);
        #1;

        dir("I32", 3'd0, 32'hFFF00093, 64'h100, 64'hFFFFFFFF, 64'h000000FF, 1'b0, 1'b1);
        dir("B32", 3'd2, 32'hFE000EE3, 64'h200, 64'hFFFFFFFC, 64'h1FC, 1'b0, 1'b1);
        dir("S32", 3'd1, 32'hFE000C23, 64'h80, 64'hFFFFFFF8, 64'h78, 1'b0, 1'b1);
        dir("U64n", 3'd3, 32'h800000B7, 64'h1000, 64'hFFFFFFFF80000000,
            64'hFFFFFFFF80001000, 1'b0, 1'b0);
        dir("U64p", 3'd3, 32'h123450B7, 64'h1000, 64'h0000000012345000,
            64'h0000000012346000, 1'b0, 1'b0);
        dir("J64", 3'd4, 32'h0010006F, 64'h10, 64'h800, 64'h810, 1'b0, 1'b0);
`ifdef IMMGEN_ZIMM_EN
        dir("Z64", 3'd5, 32'h000A8000, 64'h300, 64'h15, 64'h315, 1'b0, 1'b0);
`else
        dir("Z64", 3'd5, 32'h000A8000, 64'h300, 64'h0, 64'h300, 1'b1, 1'b0);
`endif
        dir("ILL7", 3'd7, 32'hFFF00093, 64'h400, 64'h0, 64'h400, 1'b1, 1'b0);

        // Backpressure: A and B fill both entries, C waits for space
        out_ready = 1'b0;
        d0 = delivered;
        send(3'd0, 32'h00500093, 64'h10);
        send(3'd1, 32'h00000123, 64'h20);
        @(negedge clk);
        chk("bp_in_ready", 64'(r64), 64'd0);
        chk("bp_hold_imm", imm64, 64'd5);
        repeat (3) begin
            @(negedge clk);
            chk("bp_stable_imm", imm64, 64'd5);
            chk("bp_stable_tgt", tgt64, 64'h15);
        end
        @(posedge clk);
        #1;
        fork
            send(3'd0, 32'h00700093, 64'h30);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty("bp_drain");
        chk("bp_delivered", 64'(delivered - d0), 64'd3);

        // Reset with both entries full and out_ready high
        out_ready = 1'b0;
        send(3'd0, 32'h00100093, 64'h40);
        send(3'd0, 32'h00200093, 64'h50);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(v64), 64'd0);
        chk("midrst_out_valid32", 64'(v32), 64'd0);
        chk("midrst_in_ready", 64'(r64), 64'd1);
        @(posedge clk);
        #1;

        // Mixed traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom % 2);
            in_sel    = 3'($urandom % 8);
            in_inst   = 25'($urandom);
            pc64      = {$urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_empty("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
